// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK register bank.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_MODE   = 2'd0,
    UP_MODE   = 2'd1,
    DOWN_MODE = 2'd2,
    LOAD_MODE = 2'd3
  } jk_mode_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset to a per-bit value.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic q_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= rst_val;
    end else if (en) begin
      case ({j, k})
        2'b01:   q_r <= 1'b0;
        2'b10:   q_r <= 1'b1;
        2'b11:   q_r <= ~q_r;
        default: q_r <= q_r;
      endcase
    end
  end

  assign q  = q_r;
  assign qb = ~q_r;

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of JK cells driven as raw JK, up/down counter or parallel load.
// Define JK_REG_BANK_SAT_EN to make UP/DOWN saturate instead of wrapping.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  jk_mode_t         mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] low_mask;
  logic [WIDTH-1:0] j_sel;
  logic [WIDTH-1:0] k_sel;
  logic             cell_en;

  // Toggle bit i when every lower bit is 1 (up) or 0 (down); masked AND keeps the chain flat.
  always_comb begin
    up_t     = '0;
    dn_t     = '0;
    low_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      low_mask = (WIDTH'(1) << i) - WIDTH'(1);
      up_t[i]  = &(q | ~low_mask);
      dn_t[i]  = &(qb | ~low_mask);
    end
  end

  always_comb begin
    j_sel = j;
    k_sel = k;
    case (mode)
      UP_MODE: begin
        j_sel = up_t;
        k_sel = up_t;
      end
      DOWN_MODE: begin
        j_sel = dn_t;
        k_sel = dn_t;
      end
      LOAD_MODE: begin
        j_sel = d;
        k_sel = ~d;
      end
      default: begin
        j_sel = j;
        k_sel = k;
      end
    endcase
  end

  assign tc = ((mode == UP_MODE) && (&q)) || ((mode == DOWN_MODE) && ~(|q));

`ifdef JK_REG_BANK_SAT_EN
  assign cell_en = en & ~tc;
`else
  assign cell_en = en;
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[gi]),
      .en      (cell_en),
      .j       (j_sel[gi]),
      .k       (k_sel[gi]),
      .q       (q[gi]),
      .qb      (qb[gi])
    );
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank: one instance with RST_VAL=0, one with RST_VAL=4'b0110.
module tb_jk_reg_bank;
  import jk_pkg::*;

  logic       clk;
  logic       rst;
  logic       rst1;
  logic       en;
  jk_mode_t   mode;
  logic [3:0] j, k, d;
  logic [3:0] q, qb, q1, qb1;
  logic       tc, tc1;

  int total = 0;
  int bad   = 0;

`ifdef JK_REG_BANK_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  jk_reg_bank #(.WIDTH(4), .RST_VAL(4'b0000)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q), .qb(qb), .tc(tc)
  );

  jk_reg_bank #(.WIDTH(4), .RST_VAL(4'b0110)) u_dut_rv (
    .clk(clk), .rst(rst1), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q1), .qb(qb1), .tc(tc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    rst = 1'b1; rst1 = 1'b1; en = 1'b0; mode = JK_MODE;
    j = '0; k = '0; d = '0;
    #2;
    tick();
    chk("rst_q", q, 4'h0);
    chk("rst_qb", qb, 4'hF);
    chk("rst_tc_jk", tc, 1'b0);
    chk("rst_q_rv", q1, 4'h6);
    mode = DOWN_MODE; en = 1'b1;
    tick();
    chk("rst_en_q", q, 4'h0);
    chk("rst_tc_down", tc, 1'b1);
    chk("rst_tc_down_rv", tc1, 1'b0);

    rst = 1'b0; mode = JK_MODE; en = 1'b1; j = 4'b1010; k = 4'b0101;
    tick();
    chk("jk_setclr_q", q, 4'b1010);
    chk("jk_setclr_qb", qb, 4'b0101);
    j = 4'hF; k = 4'hF;
    tick();
    chk("jk_toggle", q, 4'b0101);
    j = 4'h0; k = 4'h0;
    tick();
    chk("jk_hold", q, 4'b0101);
    j = 4'b1100; k = 4'b1010;
    tick();
    chk("jk_mixed", q, 4'b1101);

    mode = LOAD_MODE; d = 4'h0;
    tick();
    chk("load0", q, 4'h0);
    mode = UP_MODE;
    #1;
    chk("up_tc_at0", tc, 1'b0);
    for (int n = 1; n <= 16; n++) begin
      tick();
      e = (SAT && n >= 15) ? 4'hF : 4'(n);
      chk($sformatf("up_q_%0d", n), q, e);
      chk($sformatf("up_tc_%0d", n), tc, (e == 4'hF));
    end

    mode = LOAD_MODE; d = 4'b0011;
    tick();
    chk("load3", q, 4'h3);
    mode = DOWN_MODE;
    for (int n = 1; n <= 4; n++) begin
      tick();
      e = (n == 4) ? (SAT ? 4'h0 : 4'hF) : 4'(3 - n);
      chk($sformatf("dn_q_%0d", n), q, e);
      chk($sformatf("dn_tc_%0d", n), tc, (e == 4'h0));
    end

    mode = LOAD_MODE; d = 4'h7;
    tick();
    chk("load7", q, 4'h7);
    mode = UP_MODE; en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      j = ~j; k = ~k; d = ~d;
      tick();
      chk($sformatf("en0_hold_%0d", n), q, 4'h7);
    end
    en = 1'b1;
    tick();
    chk("up_after_en", q, 4'h8);
    mode = DOWN_MODE;
    tick();
    chk("mode_switch_dn", q, 4'h7);

    mode = LOAD_MODE; d = 4'hF;
    tick();
    chk("loadF", q, 4'hF);
    mode = JK_MODE;
    #1;
    chk("tc_jk_allones", tc, 1'b0);
    mode = UP_MODE;
    #1;
    chk("tc_up_allones", tc, 1'b1);
    mode = DOWN_MODE;
    #1;
    chk("tc_dn_allones", tc, 1'b0);

    rst1 = 1'b0; mode = LOAD_MODE; d = 4'h9;
    tick();
    chk("rv_load9", q1, 4'h9);
    mode = UP_MODE; rst1 = 1'b1;
    tick();
    chk("rv_midrst_q", q1, 4'h6);
    chk("rv_midrst_qb", qb1, 4'h9);
    chk("main_unaffected", q, 4'hA);
    rst1 = 1'b0;
    tick();
    chk("rv_resume7", q1, 4'h7);
    tick();
    chk("rv_resume8", q1, 4'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
